// File: rtl/alu_serial_ctrl_if.sv
// Handshake and result bus for the bit-serial ALU sequencer.
// The master issues operations; the slave (the sequencer) returns results and flags.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  ready, done, result, carry_out, zero
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, result, carry_out, zero
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one WIDTH-bit op per handshake, computed LSB-first
// through a single full-adder slice, one bit per clock.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    alu_serial_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] work;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             sum;
    logic             cy;
    logic             bit_sel;
    logic             arith;
    logic [WIDTH-1:0] next_work;

    always_comb begin
        sum     = sa[0] ^ sb[0] ^ c;
        cy      = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        arith   = (op_r == OP_ADD) || (op_r == OP_SUB);
        bit_sel = sum;
        case (op_r)
            OP_AND:  bit_sel = sa[0] & sb[0];
            OP_OR:   bit_sel = sa[0] | sb[0];
            default: bit_sel = sum;
        endcase
        next_work = {bit_sel, work[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_r          <= OP_ADD;
            sa            <= '0;
            sb            <= '0;
            work          <= '0;
            c             <= 1'b0;
            cnt           <= '0;
            bus.ready     <= 1'b1;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r      <= op_t'(bus.op);
                        sa        <= bus.a;
                        // SUB runs as a + ~b + 1: invert b here, seed carry with 1
                        sb        <= (op_t'(bus.op) == OP_SUB) ? ~bus.b : bus.b;
                        c         <= (op_t'(bus.op) == OP_SUB);
                        cnt       <= '0;
                        bus.ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work <= next_work;
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    if (arith) begin
                        c <= cy;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.result    <= next_work;
                        bus.carry_out <= arith & cy;
                        bus.zero      <= (next_work == '0);
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed vector table, random ops
// against an arithmetic reference model, back-to-back accepts and reset corners.
module tb_alu_serial_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_serial_ctrl_if #(.WIDTH(W)) bus();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cy;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         z;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int unsigned sx = x;
        int unsigned sy = y;
        int unsigned m  = 1 << W;
        int unsigned full;
        e.cy = 1'b0;
        case (o)
            2'd0: begin full = sx + sy;     e.cy = (full >= m); end
            2'd1: begin full = sx + m - sy; e.cy = (sx >= sy);  end
            2'd2: full = sx & sy;
            default: full = sx | sy;
        endcase
        e.res = W'(full % m);
        e.z   = (e.res == '0);
        return e;
    endfunction

    task automatic scramble();
        bus.op = 2'($urandom);
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output exp_t got);
        int           n = 0;
        logic [W-1:0] prev;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        prev      = bus.result;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        check("ready_after_accept", 32'(bus.ready), 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            scramble();
            if (i < W) begin
                check("done_early", 32'(bus.done), 32'd0);
                check("result_stable_run", 32'(bus.result), 32'(prev));
            end else begin
                check("done_pulse", 32'(bus.done), 32'd1);
            end
        end
        got.res = bus.result;
        got.cy  = bus.carry_out;
        got.z   = bus.zero;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("ready_after_done", 32'(bus.ready), 32'd1);
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        exp_t         got;
        exp_t         e;
        exp_t         q[$];
        logic [W-1:0] held;
        int           last_acc;
        logic         rdy;

        vecs[0] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{2'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[2] = '{2'd1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{2'd1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{2'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0};
        vecs[5] = '{2'd2, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
        vecs[6] = '{2'd3, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_carry", 32'(bus.carry_out), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, got);
            check($sformatf("vec%0d_result", i), 32'(got.res), 32'(vecs[i].res));
            check($sformatf("vec%0d_carry", i), 32'(got.cy), 32'(vecs[i].cy));
            check($sformatf("vec%0d_zero", i), 32'(got.z), 32'(vecs[i].z));
        end

        for (int i = 0; i < 30; i++) begin
            logic [1:0]   o = 2'($urandom);
            logic [W-1:0] x = W'($urandom);
            logic [W-1:0] y = (i % 5 == 0) ? x : W'($urandom);
            e = model(o, x, y);
            run_op(o, x, y, got);
            check("rand_result", 32'(got.res), 32'(e.res));
            check("rand_carry", 32'(got.cy), 32'(e.cy));
            check("rand_zero", 32'(got.z), 32'(e.z));
        end

        // start held high with inputs changing every cycle
        held     = bus.result;
        last_acc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            rdy       = bus.ready;
            bus.start = 1'b1;
            scramble();
            if (rdy) begin
                q.push_back(model(bus.op, bus.a, bus.b));
                if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'(W + 2));
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("hold_result", 32'(bus.result), 32'(e.res));
                    check("hold_carry", 32'(bus.carry_out), 32'(e.cy));
                    check("hold_zero", 32'(bus.zero), 32'(e.z));
                end
                held = bus.result;
            end else begin
                check("hold_result_stable", 32'(bus.result), 32'(held));
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_all_completed", 32'(q.size()), 32'd0);
        check("hold_accepts_seen", 32'(last_acc), 32'd30);
        repeat (2) @(negedge clk);

        // reset four bits into an ADD run
        run_op(2'd0, 8'h12, 8'h34, got);
        check("pre_abort_result", 32'(got.res), 32'h46);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 8'h77;
        bus.b     = 8'h11;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_carry", 32'(bus.carry_out), 32'd0);
        check("abort_zero", 32'(bus.zero), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        run_op(2'd0, 8'h0F, 8'h01, got);
        check("post_abort_result", 32'(got.res), 32'h10);
        check("post_abort_carry", 32'(got.cy), 32'd0);

        // reset and start on the same edge from IDLE
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("rst_start_no_done", 32'(bus.done), 32'd0);
            check("rst_start_idle", 32'(bus.ready), 32'd1);
        end
        check("rst_start_result", 32'(bus.result), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
